// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from per-bit JK flip-flop stages.
// Define JK_CNT_SAT_EN to saturate at the count limits instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] toggle_up;
  logic [WIDTH-1:0] toggle_dn;
  logic             at_top;
  logic             at_zero;
  logic             at_limit;
  logic             wrap_event;
  logic             wrap_reg;

  assign at_top   = (q_reg == MAX_COUNT);
  assign at_zero  = (q_reg == '0);
  assign at_limit = UP ? at_top : at_zero;

  // Ripple toggle enables: bit i toggles once all lower bits are 1 (up) or 0 (down)
  always_comb begin
    logic carry_up;
    logic carry_dn;
    carry_up  = EN;
    carry_dn  = EN;
    toggle_up = '0;
    toggle_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle_up[i] = carry_up;
      toggle_dn[i] = carry_dn;
      carry_up     = carry_up & q_reg[i];
      carry_dn     = carry_dn & ~q_reg[i];
    end
  end

  always_comb begin
    j          = '0;
    k          = '0;
    target     = '0;
    wrap_event = 1'b0;
    if (LOAD) begin
      target = (D > MAX_COUNT) ? MAX_COUNT : D;
      j      = target;
      k      = ~target;
    end else if (EN) begin
      if (at_limit) begin
`ifdef JK_CNT_SAT_EN
        j = '0;
        k = '0;
`else
        // Forced JK set/reset lands the wrapped value regardless of current bits
        target     = UP ? '0 : MAX_COUNT;
        j          = target;
        k          = ~target;
        wrap_event = 1'b1;
`endif
      end else if (UP) begin
        j = toggle_up;
        k = toggle_up;
      end else begin
        j = toggle_dn;
        k = toggle_dn;
      end
    end
  end

  assign q_next = (j & ~q_reg) | (~k & q_reg);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_event;
    end
  end

  assign Q    = q_reg;
  assign TC   = EN & ~LOAD & at_limit;
  assign WRAP = wrap_reg;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed testbench for jk_mod_counter (WIDTH=4, MODULUS=10); the saturating
// checks run instead of the wrap checks when JK_CNT_SAT_EN is defined.
module tb_jk_mod_counter;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       UP;
  logic       LOAD;
  logic [3:0] D;
  logic [3:0] Q;
  logic       TC;
  logic       WRAP;

  int vectorCount;
  int missCount;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (EN),
    .UP   (UP),
    .LOAD (LOAD),
    .D    (D),
    .Q    (Q),
    .TC   (TC),
    .WRAP (WRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic en, input logic up,
                               input logic load, input logic [3:0] d);
    RST_N = rst_n;
    EN    = en;
    UP    = up;
    LOAD  = load;
    D     = d;
    #1;
  endtask

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  task automatic stepAndCheck(input string tag, input logic [3:0] exp_q,
                              input logic exp_wrap);
    stepClock();
    checkOutput({tag, " Q"}, 16'(Q), 16'(exp_q));
    checkOutput({tag, " WRAP"}, 16'(WRAP), 16'(exp_wrap));
  endtask

`ifndef JK_CNT_SAT_EN
  logic [3:0] upQ    [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                              4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic       upWrap [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       upTc   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

  initial begin
    vectorCount = 0;
    missCount   = 0;

    // Reset wins over coincident LOAD and EN
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    stepAndCheck("reset1", 4'd0, 1'b0);
    stepAndCheck("reset2", 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("tc after reset down", 16'(TC), 16'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("tc after reset up", 16'(TC), 16'd0);

`ifndef JK_CNT_SAT_EN
    // Count up across the wrap
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("up tc %0d", i), 16'(TC), 16'(upTc[i]));
      stepAndCheck($sformatf("up %0d", i), upQ[i], upWrap[i]);
    end

    // Count down across the wrap from 1
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
    stepAndCheck("load 1", 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("dn tc at 1", 16'(TC), 16'd0);
    stepAndCheck("dn 0", 4'd0, 1'b0);
    checkOutput("dn tc at 0", 16'(TC), 16'd1);
    stepAndCheck("dn 9", 4'd9, 1'b1);
    stepAndCheck("dn 8", 4'd8, 1'b0);

    // Reset at terminal count: no wrap pulse leaks through
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    stepAndCheck("load 9", 4'd9, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    stepAndCheck("reset at 9", 4'd0, 1'b0);
`endif

    // Load, clamp, and LOAD overriding a pending wrap
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    checkOutput("tc during load", 16'(TC), 16'd0);
    stepAndCheck("load 7", 4'd7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd14);
    stepAndCheck("load clamp", 4'd9, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
    checkOutput("tc load at 9", 16'(TC), 16'd0);
    stepAndCheck("load over wrap", 4'd2, 1'b0);

    // Hold with EN low while UP toggles
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    stepAndCheck("load 3", 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'(i % 2), 1'b0, 4'd0);
      checkOutput($sformatf("hold tc %0d", i), 16'(TC), 16'd0);
      stepAndCheck($sformatf("hold %0d", i), 4'd3, 1'b0);
    end

`ifdef JK_CNT_SAT_EN
    // Saturate at the top
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd8);
    stepAndCheck("sat load 8", 4'd8, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++)
      stepAndCheck($sformatf("sat up %0d", i), 4'd9, 1'b0);
    checkOutput("sat tc top", 16'(TC), 16'd1);

    // Saturate at zero
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
    stepAndCheck("sat load 1", 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++)
      stepAndCheck($sformatf("sat dn %0d", i), 4'd0, 1'b0);
    checkOutput("sat tc zero", 16'(TC), 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
